call_stack: RTL

Parametrised hardware return-address stack for the pipelined MCU core, successor to the fixed 16 x 11-bit stack. It holds return PCs for CALL/RETURN, presents the top entry combinationally to the fetch stage, and adds full/empty/count status, sticky overflow/underflow error flags, and a same-cycle push+pop (replace-top) operation for tail calls. It sits beside the PC-select logic and is driven by the decode stage.

---
 rtl/mcu_pkg.sv | 7 +
 rtl/stack_regfile.sv | 23 ++
 rtl/call_stack.sv | 104 ++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU core definitions: PC width, return-stack depth and stack op decode.
package mcu_pkg;
  localparam int PC_WIDTH  = 11;
  localparam int RAS_DEPTH = 16;

  typedef enum logic [1:0] {HOLD, PUSH, POP, REPLACE} stk_op_t;
endpackage

// File: rtl/stack_regfile.sv
// Return-stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile
  import mcu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// Parametrised return-address stack with count/full/empty status and sticky error flags.
// Define CALL_STACK_WRAP_EN for legacy circular overwrite on push while full.
module call_stack
  import mcu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] stack_in,
  output logic [WIDTH-1:0] stack_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  stk_op_t          op;
  logic [AW-1:0]    ptr, ptr_n, waddr;
  logic [CW-1:0]    cnt, cnt_n;
  logic             we, ovf_set, unf_set;
  logic [WIDTH-1:0] rdata;

  assign empty = (cnt == CW'(0));
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  // push+pop on an empty stack degenerates to a plain push
  always_comb begin
    op = HOLD;
    if (push && pop && !empty) op = REPLACE;
    else if (push)             op = PUSH;
    else if (pop)              op = POP;
  end

  always_comb begin
    we      = 1'b0;
    waddr   = ptr + AW'(1);
    ptr_n   = ptr;
    cnt_n   = cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      PUSH: begin
        if (!full) begin
          we    = 1'b1;
          ptr_n = ptr + AW'(1);
          cnt_n = cnt + CW'(1);
        end else begin
          ovf_set = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          we    = 1'b1;
          ptr_n = ptr + AW'(1);
`endif
        end
      end
      POP: begin
        if (!empty) begin
          ptr_n = ptr - AW'(1);
          cnt_n = cnt - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      REPLACE: begin
        we    = 1'b1;
        waddr = ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= AW'(DEPTH - 1);
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  // writes are suppressed during reset so a held push cannot leak into the array
  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
    .clk   (clk),
    .we    (we & reset),
    .waddr (waddr),
    .wdata (stack_in),
    .raddr (ptr),
    .rdata (rdata)
  );

  assign stack_out = empty ? '0 : rdata;
endmodule
